// File: rtl/rst_seq_pkg.sv
// Shared types and cycle-count helpers for the reset sequencer.
package rst_seq_pkg;

    localparam int unsigned ERR_STAGE_W = 3;
    localparam int unsigned CNT_W       = 32;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StWaitRdy,
        StDone,
        StError
    } seq_state_e;

    function automatic logic [CNT_W-1:0] calc_delay_cyc(input int unsigned freq_mhz,
                                                        input int unsigned delay_us);
        return CNT_W'(freq_mhz * delay_us);
    endfunction

    function automatic logic [CNT_W-1:0] calc_tmo_cyc(input int unsigned freq_mhz,
                                                      input int unsigned timeout_us);
        return CNT_W'(freq_mhz * timeout_us);
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the reset sequencer and the domains it sequences.
interface rst_sequencer_if
    import rst_seq_pkg::*;
#(
    parameter int unsigned STAGES = 4
) ();

    logic                   soft_req;
    logic [STAGES-1:0]      stage_ready;
    logic [STAGES-1:0]      stage_rst_n;
    logic                   seq_done;
    logic                   seq_err;
    logic [ERR_STAGE_W-1:0] err_stage;

    modport master (
        output soft_req,
        output stage_ready,
        input  stage_rst_n,
        input  seq_done,
        input  seq_err,
        input  err_stage
    );

    modport slave (
        input  soft_req,
        input  stage_ready,
        output stage_rst_n,
        output seq_done,
        output seq_err,
        output err_stage
    );

endinterface

// File: rtl/rst_seq_timer.sv
// Clearable saturating cycle counter with terminal-count compare.
module rst_seq_timer
    import rst_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             tc_hit_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_hit_o = (cnt_q == tc_i);

endmodule

// File: rtl/rst_sequencer.sv
// Releases STAGES reset domains one at a time, waiting for each to report ready.
// Define RST_SEQ_READY_MON_EN to treat a ready drop after completion as an error.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned FREQ             = 50,
    parameter int unsigned STAGES           = 4,
    parameter int unsigned STAGE_DELAY_US   = 100,
    parameter int unsigned READY_TIMEOUT_US = 1000
) (
    input logic             sys_clk,
    input logic             sys_reset,
    rst_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0]       DELAY_CYC  = calc_delay_cyc(FREQ, STAGE_DELAY_US);
    localparam logic [CNT_W-1:0]       TMO_CYC    = calc_tmo_cyc(FREQ, READY_TIMEOUT_US);
    localparam logic [ERR_STAGE_W-1:0] LAST_STAGE = ERR_STAGE_W'(STAGES - 1);

    seq_state_e             state_q;
    logic [ERR_STAGE_W-1:0] k_q;
    logic [STAGES-1:0]      rst_n_q;
    logic                   done_q;
    logic                   err_q;
    logic [ERR_STAGE_W-1:0] err_stage_q;

    logic [STAGES-1:0] stage_sel;
    logic              rdy_k;
    logic              tc_hit;
    logic              tmr_en;
    logic              tmr_clr;
    logic [CNT_W-1:0]  tmr_tc;

    // One-hot of the current stage avoids out-of-range selects when STAGES < 8.
    always_comb begin
        stage_sel = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_sel[i] = (k_q == ERR_STAGE_W'(i));
        end
    end

    assign rdy_k  = |(bus.stage_ready & stage_sel);
    assign tmr_tc = (state_q == StWaitRdy) ? (TMO_CYC - CNT_W'(1)) : (DELAY_CYC - CNT_W'(1));

    always_comb begin
        tmr_en  = 1'b0;
        tmr_clr = 1'b1;
        unique case (state_q)
            StDelay: begin
                tmr_en  = 1'b1;
                tmr_clr = tc_hit;
            end
            StWaitRdy: begin
                tmr_en  = 1'b1;
                tmr_clr = rdy_k;
            end
            default: ;
        endcase
    end

    rst_seq_timer u_timer (
        .clk_i    (sys_clk),
        .rst_i    (sys_reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .tc_i     (tmr_tc),
        .tc_hit_o (tc_hit)
    );

`ifdef RST_SEQ_READY_MON_EN
    logic [ERR_STAGE_W-1:0] mon_idx;

    always_comb begin
        mon_idx = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (!bus.stage_ready[i]) begin
                mon_idx = ERR_STAGE_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    k_q     <= '0;
                    state_q <= StDelay;
                end
                StDelay: begin
                    if (tc_hit) begin
                        rst_n_q <= rst_n_q | stage_sel;
                        state_q <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    // Ready wins over a coincident timeout.
                    if (rdy_k) begin
                        if (k_q == LAST_STAGE) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            k_q     <= k_q + ERR_STAGE_W'(1);
                            state_q <= StDelay;
                        end
                    end else if (tc_hit) begin
                        state_q     <= StError;
                        err_q       <= 1'b1;
                        err_stage_q <= k_q;
                        rst_n_q     <= '0;
                    end
                end
                StDone: begin
                    if (bus.soft_req) begin
                        state_q <= StIdle;
                        rst_n_q <= '0;
                        done_q  <= 1'b0;
                    end
`ifdef RST_SEQ_READY_MON_EN
                    else if (!(&bus.stage_ready)) begin
                        state_q     <= StError;
                        done_q      <= 1'b0;
                        err_q       <= 1'b1;
                        err_stage_q <= mon_idx;
                        rst_n_q     <= '0;
                    end
`endif
                end
                StError: begin
                    if (bus.soft_req) begin
                        state_q     <= StIdle;
                        rst_n_q     <= '0;
                        err_q       <= 1'b0;
                        err_stage_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.stage_rst_n = rst_n_q;
    assign bus.seq_done    = done_q;
    assign bus.seq_err     = err_q;
    assign bus.err_stage   = err_stage_q;

endmodule
